// File: rtl/cpu_bus_arbiter_if.sv
// Memory-side bus of the CPU bus arbiter: one SRAM-like channel with an
// address handshake (req/addr_ok) followed by a data handshake (data_ok).
interface cpu_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    // Arbiter side: issues requests, receives handshakes and read data.
    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    // Memory side: accepts requests, returns handshakes and read data.
    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Shares one memory bus between the IF fetch port and the MEM data port.
// Data accesses win over fetches (older instruction); each access runs an
// address phase then a data phase; results are held until the pipeline
// advances, and done flags stop re-issue during unrelated stalls.
module cpu_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              stallreq_from_if,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              stallreq_from_mem,
    input  logic              pipe_stall,
    input  logic              flush_except,
    cpu_bus_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        I_ADDR,
        I_WAIT,
        D_ADDR,
        D_WAIT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              cap_data;
    logic              cap_inst;
    logic              inst_fin;
    logic              data_fin;
    logic              discard_now;
    logic              inst_done;
    logic              data_done;
    logic              inst_discard;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // A flush arriving in the very cycle the fetch completes must also drop it.
    assign discard_now = inst_discard | flush_except;

    assign stallreq_from_if  = inst_req & ~inst_done;
    assign stallreq_from_mem = data_req & ~data_done;

    assign bus.bus_req   = (state_q == I_ADDR) || (state_q == D_ADDR);
    assign bus.bus_wr    = wr_q;
    assign bus.bus_size  = size_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and per-cycle capture/completion strobes.
    always_comb begin
        state_d  = state_q;
        cap_data = 1'b0;
        cap_inst = 1'b0;
        inst_fin = 1'b0;
        data_fin = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req && !data_done) begin
                    state_d  = D_ADDR;
                    cap_data = 1'b1;
                end else if (inst_req && !inst_done) begin
                    state_d  = I_ADDR;
                    cap_inst = 1'b1;
                end
            end
            I_ADDR: if (bus.bus_addr_ok) state_d = I_WAIT;
            I_WAIT: begin
                if (bus.bus_data_ok) begin
                    state_d  = IDLE;
                    inst_fin = 1'b1;
                end
            end
            D_ADDR: if (bus.bus_addr_ok) state_d = D_WAIT;
            D_WAIT: begin
                if (bus.bus_data_ok) begin
                    state_d  = IDLE;
                    data_fin = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus request fields, loaded on leaving IDLE and held until the next access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (cap_data) begin
            wr_q    <= data_wr;
            size_q  <= data_size;
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
        end else if (cap_inst) begin
            wr_q   <= 1'b0;
            size_q <= 2'd2;
            addr_q <= inst_addr;
        end
    end

    // Returned data holding registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            if (data_fin && !wr_q) data_rdata <= bus.bus_rdata;
            if (inst_fin && !discard_now) inst_rdata <= bus.bus_rdata;
        end
    end

    // Done flags: set on completion (wins), cleared when the pipeline advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
        end else begin
            if (inst_fin && !discard_now) inst_done <= 1'b1;
            else if (!pipe_stall)         inst_done <= 1'b0;
            if (data_fin)                 data_done <= 1'b1;
            else if (!pipe_stall)         data_done <= 1'b0;
        end
    end

    // Fetch discard: marks an in-flight fetch whose result must be dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_discard <= 1'b0;
        end else if (inst_fin) begin
            inst_discard <= 1'b0;
        end else if (flush_except && (state_q == I_ADDR || state_q == I_WAIT)) begin
            inst_discard <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboarded bench for cpu_bus_arbiter: stimulus pushes expected bus
// transactions and expected read results; monitors pop and compare when the
// DUT issues an address handshake or drops a stall request on completion.
module tb_cpu_bus_arbiter;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } btx_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        stallreq_from_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        stallreq_from_mem;
    logic        pipe_stall;
    logic        flush_except;

    int n_checks = 0;
    int n_fail   = 0;

    btx_t        exp_bus[$];
    logic [31:0] exp_inst[$];
    logic [31:0] exp_data[$];

    cpu_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_rdata        (inst_rdata),
        .stallreq_from_if  (stallreq_from_if),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_rdata        (data_rdata),
        .stallreq_from_mem (stallreq_from_mem),
        .pipe_stall        (pipe_stall),
        .flush_except      (flush_except),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: wait for a request, hold addr_ok off for adly cycles,
    // then return data_ok ddly cycles after the address handshake.
    task automatic serve(input int adly, input int ddly, input logic [31:0] rd, output int waited);
        waited = 0;
        tick();
        while (!bus.bus_req && waited < 20) begin
            tick();
            waited++;
        end
        chk("req_seen", bus.bus_req, 1);
        for (int i = 0; i < adly; i++) begin
            chk("req_held", bus.bus_req, 1);
            tick();
        end
        bus.bus_addr_ok = 1'b1;
        tick();
        bus.bus_addr_ok = 1'b0;
        for (int i = 0; i < ddly; i++) begin
            chk("wait_no_req", bus.bus_req, 0);
            chk("wait_stall", stallreq_from_if | stallreq_from_mem, 1);
            tick();
        end
        bus.bus_data_ok = 1'b1;
        bus.bus_rdata   = rd;
        tick();
        bus.bus_data_ok = 1'b0;
    endtask

    // Issue monitor: every address handshake must match the next expected transfer.
    always @(negedge clk) begin
        if (rst && bus.bus_req && bus.bus_addr_ok) begin
            if (exp_bus.size() == 0) begin
                chk("unexpected_issue", {32'h0, bus.bus_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                btx_t t;
                t = exp_bus.pop_front();
                chk("issue_wr", bus.bus_wr, t.wr);
                chk("issue_size", bus.bus_size, t.size);
                chk("issue_addr", bus.bus_addr, t.addr);
                if (t.wr) chk("issue_wdata", bus.bus_wdata, t.wdata);
            end
        end
    end

    // Completion monitor: a stall dropping while its request is still up means
    // the access finished; the held read data is compared then.
    logic prev_sif  = 1'b0;
    logic prev_smem = 1'b0;
    always @(negedge clk) begin
        if (rst && prev_sif && !stallreq_from_if && inst_req) begin
            if (exp_inst.size() == 0) chk("unexpected_inst_done", inst_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("inst_rdata", inst_rdata, exp_inst.pop_front());
        end
        if (rst && prev_smem && !stallreq_from_mem && data_req) begin
            if (exp_data.size() == 0) chk("unexpected_data_done", data_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("data_rdata", data_rdata, exp_data.pop_front());
        end
        prev_sif  <= stallreq_from_if;
        prev_smem <= stallreq_from_mem;
    end

    // Stability monitor: a pending request keeps its fields until addr_ok.
    logic        prev_req = 1'b0;
    logic        prev_aok = 1'b0;
    logic [66:0] prev_fields = '0;
    always @(negedge clk) begin
        if (rst && prev_req && !prev_aok) begin
            chk("req_stable", {bus.bus_req, bus.bus_wr, bus.bus_size, bus.bus_addr, bus.bus_wdata},
                {1'b1, prev_fields});
        end
        prev_req    <= rst & bus.bus_req;
        prev_aok    <= bus.bus_addr_ok;
        prev_fields <= {bus.bus_wr, bus.bus_size, bus.bus_addr, bus.bus_wdata};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
        pipe_stall = 1'b0; flush_except = 1'b0;
        bus.bus_addr_ok = 1'b0; bus.bus_data_ok = 1'b0; bus.bus_rdata = '0;
        repeat (2) tick();

        // Reset state.
        chk("rst_bus_req", bus.bus_req, 0);
        chk("rst_bus_fields", {bus.bus_wr, bus.bus_size, bus.bus_addr, bus.bus_wdata}, 0);
        chk("rst_rdata", {inst_rdata, data_rdata}, 0);
        chk("rst_stalls", {stallreq_from_if, stallreq_from_mem}, 0);
        rst = 1'b1;
        tick();

        // Single fetch at minimum latency.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; pipe_stall = 1'b1;
        exp_bus.push_back('{1'b0, 2'd2, 32'hBFC0_0000, 32'h0});
        exp_inst.push_back(32'h3C08_BFC0);
        serve(0, 0, 32'h3C08_BFC0, w);
        chk("fetch_latency", w, 0);
        chk("fetch_stall_c3", stallreq_from_if, 0);
        chk("fetch_rdata_c3", inst_rdata, 32'h3C08_BFC0);
        pipe_stall = 1'b0;
        tick();
        inst_req = 1'b0;
        tick();

        // Simultaneous load and fetch: data first, then fetch after one IDLE cycle.
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_1000; data_wdata = 32'h5555_5555;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0010; pipe_stall = 1'b1;
        exp_bus.push_back('{1'b0, 2'd2, 32'h8000_1000, 32'h0});
        exp_bus.push_back('{1'b0, 2'd2, 32'hBFC0_0010, 32'h0});
        exp_data.push_back(32'h1122_3344);
        exp_inst.push_back(32'h2408_0001);
        serve(0, 0, 32'h1122_3344, w);
        chk("sim_mem_drops_first", {stallreq_from_mem, stallreq_from_if}, 2'b01);
        chk("sim_idle_gap", bus.bus_req, 0);
        serve(0, 0, 32'h2408_0001, w);
        pipe_stall = 1'b0;
        tick();
        inst_req = 1'b0; data_req = 1'b0;
        tick();

        // Store byte, then a divide keeps the pipeline stalled for 4 more cycles.
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h8000_0003; data_wdata = 32'h0000_00AA;
        pipe_stall = 1'b1;
        exp_bus.push_back('{1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AA});
        exp_data.push_back(32'h1122_3344);
        serve(0, 0, 32'hFFFF_FFFF, w);
        for (int i = 0; i < 4; i++) begin
            chk("store_no_reissue", bus.bus_req, 0);
            chk("store_done_held", stallreq_from_mem, 0);
            tick();
        end
        pipe_stall = 1'b0;
        tick();
        chk("store_done_cleared", stallreq_from_mem, 1);
        chk("store_no_req_after", bus.bus_req, 0);
        data_req = 1'b0;
        tick();

        // Exception flush during I_WAIT: result dropped, new vector fetched.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100; pipe_stall = 1'b1;
        exp_bus.push_back('{1'b0, 2'd2, 32'hBFC0_0100, 32'h0});
        tick();
        bus.bus_addr_ok = 1'b1;
        tick();
        bus.bus_addr_ok = 1'b0; flush_except = 1'b1;
        tick();
        flush_except = 1'b0; bus.bus_data_ok = 1'b1; bus.bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus.bus_data_ok = 1'b0;
        chk("discard_rdata", inst_rdata, 32'h2408_0001);
        chk("discard_stall", stallreq_from_if, 1);
        inst_addr = 32'hBFC0_0380;
        exp_bus.push_back('{1'b0, 2'd2, 32'hBFC0_0380, 32'h0});
        exp_inst.push_back(32'h401A_6000);
        serve(0, 0, 32'h401A_6000, w);
        pipe_stall = 1'b0;
        tick();
        inst_req = 1'b0;
        tick();

        // Slow bus: store with addr_ok 5 cycles late, then a slow load.
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h8000_0102; data_wdata = 32'h0000_BEEF;
        pipe_stall = 1'b1;
        exp_bus.push_back('{1'b1, 2'd1, 32'h8000_0102, 32'h0000_BEEF});
        exp_data.push_back(32'h1122_3344);
        serve(5, 2, 32'h0BAD_0BAD, w);
        pipe_stall = 1'b0;
        tick();
        data_req = 1'b0;
        tick();
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0200; data_wdata = 32'h7777_7777;
        pipe_stall = 1'b1;
        exp_bus.push_back('{1'b0, 2'd2, 32'h8000_0200, 32'h0});
        exp_data.push_back(32'hCAFE_F00D);
        serve(2, 3, 32'hCAFE_F00D, w);
        pipe_stall = 1'b0;
        tick();
        data_req = 1'b0;
        tick();

        // Reset asserted mid-D_WAIT; late data_ok must be ignored.
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_2000; data_wdata = 32'h9999_9999;
        pipe_stall = 1'b1;
        exp_bus.push_back('{1'b0, 2'd2, 32'h8000_2000, 32'h0});
        tick();
        bus.bus_addr_ok = 1'b1;
        tick();
        bus.bus_addr_ok = 1'b0;
        @(negedge clk);
        rst = 1'b0; data_req = 1'b0; pipe_stall = 1'b0;
        #1;
        chk("arst_bus_req", bus.bus_req, 0);
        chk("arst_bus_fields", {bus.bus_wr, bus.bus_size, bus.bus_addr, bus.bus_wdata}, 0);
        chk("arst_rdata", {inst_rdata, data_rdata}, 0);
        tick();
        bus.bus_data_ok = 1'b1; bus.bus_rdata = 32'h1234_5678;
        tick();
        bus.bus_data_ok = 1'b0;
        rst = 1'b1;
        tick();
        bus.bus_data_ok = 1'b1;
        tick();
        bus.bus_data_ok = 1'b0;
        chk("late_ok_rdata", data_rdata, 0);
        chk("late_ok_no_req", bus.bus_req, 0);

        // Recovery fetch after reset.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; pipe_stall = 1'b1;
        exp_bus.push_back('{1'b0, 2'd2, 32'hBFC0_0000, 32'h0});
        exp_inst.push_back(32'h3C08_BFC0);
        serve(0, 0, 32'h3C08_BFC0, w);
        chk("recover_latency", w, 0);
        pipe_stall = 1'b0;
        tick();
        inst_req = 1'b0;
        repeat (2) tick();

        chk("exp_bus_left", exp_bus.size(), 0);
        chk("exp_inst_left", exp_inst.size(), 0);
        chk("exp_data_left", exp_data.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
